nios_mtl_sysid_reader: RTL and testbench
========================================

// Module: nios_mtl_sysid_reader
// PURPOSE
//  Avalon-MM read master: the initiating end of the system-ID control slave. On start it reads
//  ID word (addr 0) then timestamp word (addr 1), compares both against expected constants, and
//  reports match/timeout status. Used at boot to confirm the loaded FPGA image matches the
//  software build, before the Nios MTL stack enables the display path.
// PARAMETERS
//  EXPECTED_ID        32'd0          expected word at address 0
//  EXPECTED_TS        32'd1460716791 expected word at address 1 (build timestamp)
//  USE_READDATAVALID  0              0: data captured in cycle read&&!waitrequest; 1: on readdatavalid
//  TIMEOUT_CYCLES     256            max cycles from read issue to data before abort (>=2)
//  MAX_RETRIES        3              full-sequence retries after timeout (0..15)
// PORTS
//  clock              in   1   single clock domain
//  reset              in   1   synchronous, active-high
//  start              in   1   1-cycle pulse; begins sequence when idle
//  avm_address        out  1   0=ID, 1=timestamp
//  avm_read           out  1   read strobe, held until !avm_waitrequest
//  avm_waitrequest    in   1   slave stall (tie 0 for zero-wait slave)
//  avm_readdatavalid  in   1   read data qualifier (used only if USE_READDATAVALID=1)
//  avm_readdata       in   32  read data
//  id_value           out  32  captured ID word
//  ts_value           out  32  captured timestamp word
//  busy               out  1   sequence in progress
//  done               out  1   level; sequence finished (pass, mismatch or timeout)
//  id_match           out  1   id_value==EXPECTED_ID, valid when done
//  ts_match           out  1   ts_value==EXPECTED_TS, valid when done
//  timeout_err        out  1   retries exhausted, valid when done
//  retry_count        out  4   timeouts taken in current/last sequence
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. Reset mid-sequence: avm_read low from the edge after reset
//    is sampled; late readdatavalid afterwards ignored.
//  - All outputs registered. States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, DONE.
//  - IDLE/DONE + start: clear done/match/timeout_err/retry_count/values, busy=1, go REQ_ID.
//    start while busy ignored.
//  - REQ_x: avm_read=1, avm_address=x (0 or 1); hold address/read stable while waitrequest=1.
//    USE_READDATAVALID=0: on read&&!waitrequest capture readdata, go to next REQ/CHECK directly.
//    USE_READDATAVALID=1: on acceptance drop read, go WAIT_x; capture on first readdatavalid
//    (never same cycle as acceptance); readdatavalid in any other state ignored.
//  - Timer: clears on entering REQ_ID/REQ_TS, counts each cycle in REQ_x/WAIT_x; reaching
//    TIMEOUT_CYCLES aborts (read low next cycle). If retry_count<MAX_RETRIES: increment, restart
//    at REQ_ID (ID re-read); else timeout_err=1, go DONE with matches 0.
//  - CHECK: one cycle, registers id_match, ts_match; next DONE: done=1, busy=0.
//  - Mismatch is not retried; reported via match flags only.
//  - Latency (zero-wait, USE_READDATAVALID=0): start sampled edge k; read addr0 cycle k+1,
//    addr1 cycle k+2, CHECK k+3, done=1 from k+4.
//  - Timeout and data arriving in same cycle: data wins, no timeout.
//  - retry_count saturates at MAX_RETRIES; done holds until next start or reset.
// STRUCTURE
//  - Package nios_mtl_sysid_pkg: state enum, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1,
//    data width 32.
//  - Sub-module nios_mtl_sysid_rd_timer: clear/enable counter, timeout flag at TIMEOUT_CYCLES.
//  - FSM, capture registers and compare in top.
// TESTING
//  1 Zero-wait slave (addr?1460716791:0), start -> reads addr0 then addr1 on consecutive cycles,
//    done at k+4, id_value=0, ts_value=1460716791, id_match=ts_match=1, retry_count=0.
//  2 waitrequest=1 for 5 cycles on addr1 -> address/read held stable, done at k+9, matches=1.
//  3 Slave returns ts 32'h1234_5678 -> done, id_match=1, ts_match=0, timeout_err=0, no retry.
//  4 USE_READDATAVALID=1, TIMEOUT_CYCLES=8, readdatavalid never -> 4 sequences (retry_count 1..3),
//    then timeout_err=1, done=1.
//  5 reset pulsed while waitrequest held in REQ_TS -> next cycle read=0, busy=0, all outputs 0;
//    fresh start completes normally.
//  6 start pulses while busy and stray readdatavalid in IDLE -> ignored, single sequence only.

Source files
------------

// File: rtl/nios_mtl_sysid_pkg.sv
// Shared types and constants for the system-ID reader and its read timer.
package nios_mtl_sysid_pkg;

  localparam int   SYSID_DATA_W  = 32;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_WAIT_ID,
    ST_REQ_TS,
    ST_WAIT_TS,
    ST_CHECK,
    ST_DONE
  } sysid_state_e;

  // States in which a read request is being presented on the bus.
  function automatic logic is_req(input sysid_state_e s);
    return (s == ST_REQ_ID) || (s == ST_REQ_TS);
  endfunction

  // States in which a read is outstanding and the timeout timer runs.
  function automatic logic is_active(input sysid_state_e s);
    return (s == ST_REQ_ID) || (s == ST_WAIT_ID) ||
           (s == ST_REQ_TS) || (s == ST_WAIT_TS);
  endfunction

endpackage

// File: rtl/nios_mtl_sysid_rd_timer.sv
// Read timeout timer: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT_CYCLES-th enabled cycle is reached.
module nios_mtl_sysid_rd_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int          CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Cycle counter; clear has priority, holds at LAST so it can never wrap.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_timeout = i_en && (r_count == LAST);

endmodule

// File: rtl/nios_mtl_sysid_reader.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words,
// compares them with the expected constants and reports match/timeout status.
module nios_mtl_sysid_reader
  import nios_mtl_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID       = 32'd0,
  parameter logic [31:0] EXPECTED_TS       = 32'd1460716791,
  parameter bit          USE_READDATAVALID = 1'b0,
  parameter int          TIMEOUT_CYCLES    = 256,
  parameter int          MAX_RETRIES       = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic                    avm_readdatavalid,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value,
  output logic                    busy,
  output logic                    done,
  output logic                    id_match,
  output logic                    ts_match,
  output logic                    timeout_err,
  output logic [3:0]              retry_count
);

  localparam logic [3:0] MAX_RETRY_CNT = 4'(MAX_RETRIES);

  sysid_state_e r_state;
  sysid_state_e w_state_next;

  logic                    r_read;
  logic                    r_addr;
  logic [SYSID_DATA_W-1:0] r_id_value;
  logic [SYSID_DATA_W-1:0] r_ts_value;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_id_match;
  logic                    r_ts_match;
  logic                    r_timeout_err;
  logic [3:0]              r_retry_count;

  logic w_read_next;
  logic w_addr_next;
  logic w_accept;
  logic w_timeout;
  logic w_timer_clr;
  logic w_timer_en;
  logic w_abort;
  logic w_start_seq;
  logic w_cap_id;
  logic w_cap_ts;
  logic w_retry;
  logic w_fail;

  // r_read is only ever high in a REQ state, so this is a bus-level acceptance.
  assign w_accept   = r_read && !avm_waitrequest;
  assign w_timer_en = is_active(r_state);

  nios_mtl_sysid_rd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_timeout(w_timeout)
  );

  // Next-state, capture strobes and next bus-output values.
  always_comb begin
    w_state_next = r_state;
    w_timer_clr  = 1'b0;
    w_abort      = 1'b0;
    w_start_seq  = 1'b0;
    w_cap_id     = 1'b0;
    w_cap_ts     = 1'b0;
    w_retry      = 1'b0;
    w_fail       = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_start_seq  = 1'b1;
          w_timer_clr  = 1'b1;
          w_state_next = ST_REQ_ID;
        end
      end
      ST_REQ_ID: begin
        // Data (or acceptance) beats a timeout landing in the same cycle.
        if (w_accept) begin
          if (USE_READDATAVALID) begin
            w_state_next = ST_WAIT_ID;
          end else begin
            w_cap_id     = 1'b1;
            w_timer_clr  = 1'b1;
            w_state_next = ST_REQ_TS;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      ST_WAIT_ID: begin
        if (avm_readdatavalid) begin
          w_cap_id     = 1'b1;
          w_timer_clr  = 1'b1;
          w_state_next = ST_REQ_TS;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      ST_REQ_TS: begin
        if (w_accept) begin
          if (USE_READDATAVALID) begin
            w_state_next = ST_WAIT_TS;
          end else begin
            w_cap_ts     = 1'b1;
            w_state_next = ST_CHECK;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      ST_WAIT_TS: begin
        if (avm_readdatavalid) begin
          w_cap_ts     = 1'b1;
          w_state_next = ST_CHECK;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      ST_CHECK: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // A timeout restarts the whole sequence from the ID word until the
    // retry budget is spent, then gives up with the match flags still clear.
    if (w_abort) begin
      if (r_retry_count < MAX_RETRY_CNT) begin
        w_retry      = 1'b1;
        w_timer_clr  = 1'b1;
        w_state_next = ST_REQ_ID;
      end else begin
        w_fail       = 1'b1;
        w_state_next = ST_DONE;
      end
    end

    // An aborted read drops the strobe for one cycle before re-issuing.
    w_read_next = is_req(w_state_next) && !w_abort;
    w_addr_next = ((w_state_next == ST_REQ_TS) || (w_state_next == ST_WAIT_TS)) ?
                  SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  // State, bus outputs, capture registers and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_read        <= 1'b0;
      r_addr        <= SYSID_ADDR_ID;
      r_id_value    <= '0;
      r_ts_value    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_id_match    <= 1'b0;
      r_ts_match    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_retry_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_read  <= w_read_next;
      r_addr  <= w_addr_next;

      if (w_start_seq) begin
        r_id_value    <= '0;
        r_ts_value    <= '0;
        r_id_match    <= 1'b0;
        r_ts_match    <= 1'b0;
        r_timeout_err <= 1'b0;
        r_retry_count <= '0;
        r_done        <= 1'b0;
        r_busy        <= 1'b1;
      end

      if (w_cap_id) begin
        r_id_value <= avm_readdata;
      end
      if (w_cap_ts) begin
        r_ts_value <= avm_readdata;
      end
      if (w_retry) begin
        r_retry_count <= r_retry_count + 1'b1;
      end
      if (w_fail) begin
        r_timeout_err <= 1'b1;
      end

      if (r_state == ST_CHECK) begin
        r_id_match <= (r_id_value == EXPECTED_ID);
        r_ts_match <= (r_ts_value == EXPECTED_TS);
      end

      if ((w_state_next == ST_DONE) && (r_state != ST_DONE)) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign timeout_err = r_timeout_err;
  assign retry_count = r_retry_count;

endmodule

// File: tb/tb_nios_mtl_sysid_reader.sv
// Self-checking bench: a zero/variable-wait slave on DUT1 (readdata captured at
// acceptance) and a readdatavalid slave on DUT2 (short timeout for retry tests).
module tb_nios_mtl_sysid_reader;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1460716791;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset  = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;

  // DUT1 bus and status
  logic        a1_addr, a1_read;
  logic        a1_wait  = 1'b0;
  logic        a1_rdv   = 1'b0;
  logic [31:0] a1_rdata = '0;
  logic [31:0] id1, ts1;
  logic        busy1, done1, idm1, tsm1, terr1;
  logic [3:0]  rc1;

  // DUT2 bus and status
  logic        a2_addr, a2_read;
  logic        a2_wait  = 1'b0;
  logic        a2_rdv   = 1'b0;
  logic [31:0] a2_rdata = '0;
  logic [31:0] id2, ts2;
  logic        busy2, done2, idm2, tsm2, terr2;
  logic [3:0]  rc2;

  nios_mtl_sysid_reader dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .avm_address(a1_addr), .avm_read(a1_read), .avm_waitrequest(a1_wait),
    .avm_readdatavalid(a1_rdv), .avm_readdata(a1_rdata),
    .id_value(id1), .ts_value(ts1), .busy(busy1), .done(done1),
    .id_match(idm1), .ts_match(tsm1), .timeout_err(terr1), .retry_count(rc1)
  );

  nios_mtl_sysid_reader #(
    .USE_READDATAVALID(1'b1), .TIMEOUT_CYCLES(8)
  ) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .avm_address(a2_addr), .avm_read(a2_read), .avm_waitrequest(a2_wait),
    .avm_readdatavalid(a2_rdv), .avm_readdata(a2_rdata),
    .id_value(id2), .ts_value(ts2), .busy(busy2), .done(done2),
    .id_match(idm2), .ts_match(tsm2), .timeout_err(terr2), .retry_count(rc2)
  );

  // ---------------- slave 1: waitrequest per address, data at acceptance
  logic [31:0] cfg1_data [2];
  int          cfg1_wait [2];
  int          cfg1_gen = 0;
  int          s1_gen   = 0;
  int          s1_wait_left [2];
  int          s1_rd_cycles [2];
  int          s1_acc [$];

  always @(negedge clock) begin
    if (cfg1_gen != s1_gen) begin
      s1_gen = cfg1_gen;
      for (int a = 0; a < 2; a++) begin
        s1_wait_left[a] = cfg1_wait[a];
        s1_rd_cycles[a] = 0;
      end
      s1_acc.delete();
    end
    a1_wait = 1'b0;
    if (a1_read === 1'b1) begin
      s1_rd_cycles[a1_addr]++;
      if (s1_wait_left[a1_addr] > 0) begin
        a1_wait = 1'b1;
        s1_wait_left[a1_addr]--;
      end else begin
        a1_rdata = cfg1_data[a1_addr];
        s1_acc.push_back(int'(a1_addr));
      end
    end
  end

  // ---------------- slave 2: zero-wait, readdatavalid after a latency
  logic [31:0] cfg2_data [2];
  int          cfg2_lat  = 0;   // 0 = never answer
  int          cfg2_gen  = 0;
  int          s2_gen    = 0;
  logic        stray2    = 1'b0;
  logic [31:0] stray2_data = '0;
  int          s2_pend   = 0;
  logic        s2_pend_addr = 1'b0;
  int          s2_acc [2];

  always @(negedge clock) begin
    if (cfg2_gen != s2_gen) begin
      s2_gen    = cfg2_gen;
      s2_pend   = 0;
      s2_acc[0] = 0;
      s2_acc[1] = 0;
    end
    a2_rdv = 1'b0;
    if (s2_pend > 0) begin
      s2_pend--;
      if (s2_pend == 0) begin
        a2_rdv   = 1'b1;
        a2_rdata = cfg2_data[s2_pend_addr];
      end
    end
    if (stray2) begin
      a2_rdv   = 1'b1;
      a2_rdata = stray2_data;
    end
    if (a2_read === 1'b1) begin
      s2_acc[a2_addr]++;
      if (cfg2_lat > 0) begin
        s2_pend      = cfg2_lat;
        s2_pend_addr = a2_addr;
      end
    end
  end

  // ---------------- checking
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one sequence on DUT1; extra_starts pulses start twice while busy.
  task automatic run1(input string tag, input logic [31:0] idd, input logic [31:0] tsd,
                      input int w0, input int w1, input logic em_id, input logic em_ts,
                      input int exp_n, input bit extra_starts);
    int n;
    int order;
    @(negedge clock);
    cfg1_data[0] = idd;
    cfg1_data[1] = tsd;
    cfg1_wait[0] = w0;
    cfg1_wait[1] = w1;
    cfg1_gen++;
    start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    chk({tag, "_busy_hi"}, 32'(busy1), 32'd1);
    n = 0;
    while (!done1 && n < 1000) begin
      @(posedge clock); #1;
      n++;
      start1 = extra_starts && (n == 1 || n == 3);
    end
    start1 = 1'b0;
    order = (s1_acc.size() == 2) ? (s1_acc[0] * 2 + s1_acc[1]) : 99;
    chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    chk({tag, "_id_value"}, id1, idd);
    chk({tag, "_ts_value"}, ts1, tsd);
    chk({tag, "_flags"}, {27'd0, busy1, idm1, tsm1, terr1, done1},
        {27'd0, 1'b0, em_id, em_ts, 1'b0, 1'b1});
    chk({tag, "_retry"}, 32'(rc1), 32'd0);
    chk({tag, "_rd_cycles0"}, 32'(s1_rd_cycles[0]), 32'(w0 + 1));
    chk({tag, "_rd_cycles1"}, 32'(s1_rd_cycles[1]), 32'(w1 + 1));
    chk({tag, "_acc_order"}, 32'(order), 32'd1);
    $display("txn %s: id=%0h ts=%0h lat=%0d idm=%0b tsm=%0b", tag, id1, ts1, n, idm1, tsm1);
  endtask

  typedef struct {
    logic [31:0] idd;
    logic [31:0] tsd;
    int          w0;
    int          w1;
    logic        em_id;
    logic        em_ts;
    int          exp_n;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int w0, w1;
    logic [31:0] idd, tsd;
    logic [3:0] seen;

    vecs[0] = '{32'd0,          EXP_TS,        0, 0, 1'b1, 1'b1, 3};
    vecs[1] = '{32'd0,          EXP_TS,        0, 5, 1'b1, 1'b1, 8};
    vecs[2] = '{32'd0,          32'h1234_5678, 0, 0, 1'b1, 1'b0, 3};
    vecs[3] = '{32'hDEAD_BEEF,  EXP_TS,        3, 1, 1'b0, 1'b1, 7};
    vecs[4] = '{32'h0000_0001,  32'd0,         2, 2, 1'b0, 1'b0, 7};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_dut1", {a1_read, a1_addr, busy1, done1, idm1, tsm1, terr1, rc1, |id1, |ts1}, '0);
    chk("reset_dut2", {a2_read, a2_addr, busy2, done2, idm2, tsm2, terr2, rc2, |id2, |ts2}, '0);
    @(negedge clock);
    reset = 1'b0;

    // Stray readdatavalid while DUT2 idle must not be captured
    @(negedge clock); stray2 = 1'b1; stray2_data = 32'hCAFE_F00D;
    @(negedge clock); stray2 = 1'b0;
    @(posedge clock); #1;
    chk("stray_idle", {id2, ts2, 7'd0, busy2}, '0);

    // Table-driven sequences on DUT1
    for (int i = 0; i < 5; i++) begin
      run1($sformatf("vec%0d", i), vecs[i].idd, vecs[i].tsd, vecs[i].w0, vecs[i].w1,
           vecs[i].em_id, vecs[i].em_ts, vecs[i].exp_n, 1'b0);
    end

    // Randomized sequences against the transaction-level model
    for (int i = 0; i < 8; i++) begin
      w0  = $urandom_range(0, 6);
      w1  = $urandom_range(0, 6);
      idd = ($urandom_range(0, 1) != 0) ? EXP_ID : 32'($urandom);
      tsd = ($urandom_range(0, 1) != 0) ? EXP_TS : 32'($urandom);
      run1($sformatf("rnd%0d", i), idd, tsd, w0, w1, idd == EXP_ID, tsd == EXP_TS,
           3 + w0 + w1, 1'b0);
    end

    // Start pulses while busy are ignored; done holds afterwards
    run1("start_busy", EXP_ID, EXP_TS, 1, 4, 1'b1, 1'b1, 8, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    chk("done_hold", {31'd0, done1}, 32'd1);

    // Reset while waitrequest holds the timestamp read
    @(negedge clock);
    cfg1_data[0] = 32'hA5A5_0000;
    cfg1_data[1] = EXP_TS;
    cfg1_wait[0] = 0;
    cfg1_wait[1] = 1000;
    cfg1_gen++;
    start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("hold_addr_read", {30'd0, a1_read, a1_addr}, 32'd3);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("reset_mid", {a1_read, a1_addr, busy1, done1, idm1, tsm1, terr1, rc1, |id1, |ts1}, '0);
    @(negedge clock); reset = 1'b0;
    run1("after_reset", EXP_ID, EXP_TS, 0, 0, 1'b1, 1'b1, 3, 1'b0);

    // DUT2: readdatavalid two cycles after acceptance
    @(negedge clock);
    cfg2_data[0] = EXP_ID;
    cfg2_data[1] = EXP_TS;
    cfg2_lat     = 2;
    cfg2_gen++;
    start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    chk("rdv_latency", 32'(n), 32'd7);
    chk("rdv_values", {id2 ^ EXP_ID} | {ts2 ^ EXP_TS}, 32'd0);
    chk("rdv_flags", {27'd0, busy2, idm2, tsm2, terr2, rc2 != 0}, {27'd0, 5'b01100});
    $display("txn rdv: id=%0h ts=%0h lat=%0d", id2, ts2, n);

    // Stray readdatavalid while DONE must not overwrite captures
    @(negedge clock); stray2 = 1'b1; stray2_data = 32'h1111_2222;
    @(negedge clock); stray2 = 1'b0;
    @(posedge clock); #1;
    chk("stray_done_ts", ts2, EXP_TS);

    // DUT2: readdatavalid never arrives -> three retries then timeout_err
    @(negedge clock);
    cfg2_lat = 0;
    cfg2_gen++;
    start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    seen = '0;
    n = 0;
    while (!done2 && n < 500) begin
      if (busy2) seen[rc2[1:0]] = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    chk("to_done", {31'd0, done2}, 32'd1);
    chk("to_retry_seen", 32'(seen), 32'hF);
    chk("to_flags", {27'd0, busy2, idm2, tsm2, terr2, 1'b0}, {27'd0, 5'b00010});
    chk("to_retry_count", 32'(rc2), 32'd3);
    chk("to_id_reads", 32'(s2_acc[0]), 32'd4);
    chk("to_ts_reads", 32'(s2_acc[1]), 32'd0);
    $display("txn timeout: retry=%0d err=%0b cycles=%0d", rc2, terr2, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
